// File: rtl/gb_cpu_pkg.sv
// Shared types and decode tables for the Game Boy CPU fetch/classify stage.
package gb_cpu_pkg;

  localparam logic [6:0] ILLEGAL_IDX = 7'd84;
  localparam logic [7:0] CB_PREFIX   = 8'hCB;

  typedef enum logic [2:0] {
    StFetchOp,
    StFetchCb,
    StFetchLo,
    StFetchHi,
    StPresent
  } fetch_state_e;

  // Base-page classes: 0 NOP, 1 LD rr,d16, 2 LD (rr),A, 3 INC rr, 4 INC r, 5 DEC r, 6 LD r,d8,
  // 7 RLCA, 8 LD (a16),SP, 9 ADD HL,rr, 10 LD A,(rr), 11 DEC rr, 12 RRCA, 13 STOP, 14 RLA,
  // 15 JR, 16 RRA, 17 JR cc, 18 LDI (HL),A, 19 DAA, 20 LDI A,(HL), 21 CPL, 22 LDD (HL),A,
  // 23 INC (HL), 24 DEC (HL), 25 LD (HL),d8, 26 SCF, 27 LDD A,(HL), 28 CCF, 29 LD r,r,
  // 30 LD r,(HL), 31 LD (HL),r, 32 HALT, 33 ALU r, 34 ALU (HL), 35 RET cc, 36 POP, 37 JP cc,
  // 38 JP, 39 CALL cc, 40 PUSH, 41 ALU d8, 42 RST, 43 RET, 44 CB prefix, 45 CALL, 46 RETI,
  // 47 LDH (a8),A, 48 LDH (C),A, 49 ADD SP,e8, 50 JP HL, 51 LD (a16),A, 52 LDH A,(a8),
  // 53 LDH A,(C), 54 DI, 55 LD HL,SP+e8, 56 LD SP,HL, 57 LD A,(a16), 58 EI, 84 illegal.
  localparam logic [6:0] OPCLASS_LUT [256] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 4, 5, 6, 12,
    13, 1, 2, 3, 4, 5, 6, 14, 15, 9, 10, 11, 4, 5, 6, 16,
    17, 1, 18, 3, 4, 5, 6, 19, 17, 9, 20, 11, 4, 5, 6, 21,
    17, 1, 22, 3, 23, 24, 25, 26, 17, 9, 27, 11, 4, 5, 6, 28,
    29, 29, 29, 29, 29, 29, 30, 29, 29, 29, 29, 29, 29, 29, 30, 29,
    29, 29, 29, 29, 29, 29, 30, 29, 29, 29, 29, 29, 29, 29, 30, 29,
    29, 29, 29, 29, 29, 29, 30, 29, 29, 29, 29, 29, 29, 29, 30, 29,
    31, 31, 31, 31, 31, 31, 32, 31, 29, 29, 29, 29, 29, 29, 30, 29,
    33, 33, 33, 33, 33, 33, 34, 33, 33, 33, 33, 33, 33, 33, 34, 33,
    33, 33, 33, 33, 33, 33, 34, 33, 33, 33, 33, 33, 33, 33, 34, 33,
    33, 33, 33, 33, 33, 33, 34, 33, 33, 33, 33, 33, 33, 33, 34, 33,
    33, 33, 33, 33, 33, 33, 34, 33, 33, 33, 33, 33, 33, 33, 34, 33,
    35, 36, 37, 38, 39, 40, 41, 42, 35, 43, 37, 44, 39, 45, 41, 42,
    35, 36, 37, 84, 39, 40, 41, 42, 35, 46, 37, 84, 39, 84, 41, 42,
    47, 36, 48, 84, 84, 40, 41, 42, 49, 50, 51, 84, 84, 84, 41, 42,
    52, 36, 53, 54, 84, 40, 41, 42, 55, 56, 57, 58, 84, 84, 41, 42
  };

  // CB-page classes: rotate/shift ops in pairs (register, (HL)) from 59 (RLC) to 74 (SRL),
  // then 75/76 BIT, 77/78 RES, 79/80 SET.
  localparam logic [6:0] CB_OPCLASS_LUT [256] = '{
    59, 59, 59, 59, 59, 59, 60, 59, 61, 61, 61, 61, 61, 61, 62, 61,
    63, 63, 63, 63, 63, 63, 64, 63, 65, 65, 65, 65, 65, 65, 66, 65,
    67, 67, 67, 67, 67, 67, 68, 67, 69, 69, 69, 69, 69, 69, 70, 69,
    71, 71, 71, 71, 71, 71, 72, 71, 73, 73, 73, 73, 73, 73, 74, 73,
    75, 75, 75, 75, 75, 75, 76, 75, 75, 75, 75, 75, 75, 75, 76, 75,
    75, 75, 75, 75, 75, 75, 76, 75, 75, 75, 75, 75, 75, 75, 76, 75,
    75, 75, 75, 75, 75, 75, 76, 75, 75, 75, 75, 75, 75, 75, 76, 75,
    75, 75, 75, 75, 75, 75, 76, 75, 75, 75, 75, 75, 75, 75, 76, 75,
    77, 77, 77, 77, 77, 77, 78, 77, 77, 77, 77, 77, 77, 77, 78, 77,
    77, 77, 77, 77, 77, 77, 78, 77, 77, 77, 77, 77, 77, 77, 78, 77,
    77, 77, 77, 77, 77, 77, 78, 77, 77, 77, 77, 77, 77, 77, 78, 77,
    77, 77, 77, 77, 77, 77, 78, 77, 77, 77, 77, 77, 77, 77, 78, 77,
    79, 79, 79, 79, 79, 79, 80, 79, 79, 79, 79, 79, 79, 79, 80, 79,
    79, 79, 79, 79, 79, 79, 80, 79, 79, 79, 79, 79, 79, 79, 80, 79,
    79, 79, 79, 79, 79, 79, 80, 79, 79, 79, 79, 79, 79, 79, 80, 79,
    79, 79, 79, 79, 79, 79, 80, 79, 79, 79, 79, 79, 79, 79, 80, 79
  };

  // Immediate bytes following the opcode; STOP carries its padding byte as an immediate.
  localparam logic [1:0] IMM_LEN_LUT [256] = '{
    0, 2, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0,
    1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0,
    1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0,
    1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 2, 2, 2, 0, 1, 0, 0, 0, 2, 0, 2, 2, 1, 0,
    0, 0, 2, 0, 2, 0, 1, 0, 0, 0, 2, 0, 2, 0, 1, 0,
    1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 0,
    1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 0
  };

endpackage

// File: rtl/opcode_fetch_if.sv
// Memory read port plus decoded-instruction handshake between fetch and sequencer.
interface opcode_fetch_if;

  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;

  logic        op_valid;
  logic        op_ready;
  logic [6:0]  op_index;
  logic [7:0]  op_raw;
  logic        op_cb;
  logic        op_illegal;
  logic [15:0] imm;
  logic [1:0]  imm_len;
  logic [15:0] next_pc;

  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output rd_req, rd_addr, op_valid, op_index, op_raw, op_cb, op_illegal, imm, imm_len,
           next_pc,
    input  rd_ack, rd_data, op_ready, redirect, redirect_pc
  );

  modport slave (
    input  rd_req, rd_addr, op_valid, op_index, op_raw, op_cb, op_illegal, imm, imm_len,
           next_pc,
    output rd_ack, rd_data, op_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/opclass_decode.sv
// Combinational opcode classifier: byte (base or CB page) to class index and immediate length.
module opclass_decode
  import gb_cpu_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       is_cb_i,
  output logic [6:0] index_o,
  output logic [1:0] imm_len_o,
  output logic       illegal_o
);

  // Table lookup; CB-page instructions never carry immediates and are never illegal.
  always_comb begin
    index_o   = OPCLASS_LUT[byte_i];
    imm_len_o = IMM_LEN_LUT[byte_i];
    illegal_o = (OPCLASS_LUT[byte_i] == ILLEGAL_IDX);
    if (is_cb_i) begin
      index_o   = CB_OPCLASS_LUT[byte_i];
      imm_len_o = 2'd0;
      illegal_o = 1'b0;
    end
  end

endmodule

// File: rtl/opcode_fetch.sv
// Single-instruction-in-flight fetch/classify stage feeding the microcode sequencer.
module opcode_fetch
  import gb_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
  opcode_fetch_if.master fetch_io
);

  fetch_state_e state_q, state_d;
  logic [15:0]  fpc_q, fpc_d;
  logic         rd_req_q, rd_req_d;
  logic [15:0]  rd_addr_q, rd_addr_d;
  logic         op_valid_q, op_valid_d;
  logic [6:0]   op_index_q, op_index_d;
  logic [7:0]   op_raw_q, op_raw_d;
  logic         op_cb_q, op_cb_d;
  logic         op_illegal_q, op_illegal_d;
  logic [15:0]  imm_q, imm_d;
  logic [1:0]   imm_len_q, imm_len_d;
  logic [15:0]  next_pc_q, next_pc_d;

  logic         dec_is_cb;
  logic [6:0]   dec_index;
  logic [1:0]   dec_imm_len;
  logic         dec_illegal;
  logic         ack;
  logic [15:0]  fpc_inc;

  assign dec_is_cb = (state_q == StFetchCb);
  // An ack only counts against a request we are actually driving.
  assign ack       = fetch_io.rd_ack && rd_req_q;
  assign fpc_inc   = fpc_q + 16'd1;

  opclass_decode u_decode (
    .byte_i   (fetch_io.rd_data),
    .is_cb_i  (dec_is_cb),
    .index_o  (dec_index),
    .imm_len_o(dec_imm_len),
    .illegal_o(dec_illegal)
  );

  // Next-state, fetch pointer and registered-output updates.
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    op_valid_d   = op_valid_q;
    op_index_d   = op_index_q;
    op_raw_d     = op_raw_q;
    op_cb_d      = op_cb_q;
    op_illegal_d = op_illegal_q;
    imm_d        = imm_q;
    imm_len_d    = imm_len_q;
    next_pc_d    = next_pc_q;

    if (fetch_io.redirect) begin
      // Drop whatever is in flight and restart at the new pointer right away.
      state_d    = StFetchOp;
      fpc_d      = fetch_io.redirect_pc;
      rd_req_d   = 1'b1;
      rd_addr_d  = fetch_io.redirect_pc;
      op_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StFetchOp: begin
          if (!rd_req_q) begin
            // Only reachable straight out of reset.
            rd_req_d  = 1'b1;
            rd_addr_d = fpc_q;
          end else if (ack) begin
            fpc_d        = fpc_inc;
            rd_addr_d    = fpc_inc;
            op_raw_d     = fetch_io.rd_data;
            op_index_d   = dec_index;
            op_illegal_d = dec_illegal;
            imm_len_d    = dec_imm_len;
            op_cb_d      = 1'b0;
            imm_d        = 16'h0000;
            if (fetch_io.rd_data == CB_PREFIX) begin
              op_cb_d = 1'b1;
              state_d = StFetchCb;
            end else if (dec_imm_len != 2'd0) begin
              state_d = StFetchLo;
            end else begin
              state_d    = StPresent;
              rd_req_d   = 1'b0;
              op_valid_d = 1'b1;
              next_pc_d  = fpc_inc;
            end
          end
        end
        StFetchCb: begin
          if (ack) begin
            fpc_d        = fpc_inc;
            rd_addr_d    = fpc_inc;
            op_raw_d     = fetch_io.rd_data;
            op_index_d   = dec_index;
            op_illegal_d = dec_illegal;
            imm_len_d    = dec_imm_len;
            state_d      = StPresent;
            rd_req_d     = 1'b0;
            op_valid_d   = 1'b1;
            next_pc_d    = fpc_inc;
          end
        end
        StFetchLo: begin
          if (ack) begin
            fpc_d      = fpc_inc;
            rd_addr_d  = fpc_inc;
            imm_d[7:0] = fetch_io.rd_data;
            if (imm_len_q == 2'd2) begin
              state_d = StFetchHi;
            end else begin
              state_d    = StPresent;
              rd_req_d   = 1'b0;
              op_valid_d = 1'b1;
              next_pc_d  = fpc_inc;
            end
          end
        end
        StFetchHi: begin
          if (ack) begin
            fpc_d       = fpc_inc;
            rd_addr_d   = fpc_inc;
            imm_d[15:8] = fetch_io.rd_data;
            state_d     = StPresent;
            rd_req_d    = 1'b0;
            op_valid_d  = 1'b1;
            next_pc_d   = fpc_inc;
          end
        end
        StPresent: begin
          if (fetch_io.op_ready) begin
            state_d    = StFetchOp;
            op_valid_d = 1'b0;
            rd_req_d   = 1'b1;
            rd_addr_d  = fpc_q;
          end
        end
        default: begin
          state_d = StFetchOp;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetchOp;
      fpc_q        <= RESET_PC;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= 16'h0000;
      op_valid_q   <= 1'b0;
      op_index_q   <= 7'd0;
      op_raw_q     <= 8'h00;
      op_cb_q      <= 1'b0;
      op_illegal_q <= 1'b0;
      imm_q        <= 16'h0000;
      imm_len_q    <= 2'd0;
      next_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      op_valid_q   <= op_valid_d;
      op_index_q   <= op_index_d;
      op_raw_q     <= op_raw_d;
      op_cb_q      <= op_cb_d;
      op_illegal_q <= op_illegal_d;
      imm_q        <= imm_d;
      imm_len_q    <= imm_len_d;
      next_pc_q    <= next_pc_d;
    end
  end

  assign fetch_io.rd_req     = rd_req_q;
  assign fetch_io.rd_addr    = rd_addr_q;
  assign fetch_io.op_valid   = op_valid_q;
  assign fetch_io.op_index   = op_index_q;
  assign fetch_io.op_raw     = op_raw_q;
  assign fetch_io.op_cb      = op_cb_q;
  assign fetch_io.op_illegal = op_illegal_q;
  assign fetch_io.imm        = imm_q;
  assign fetch_io.imm_len    = imm_len_q;
  assign fetch_io.next_pc    = next_pc_q;

endmodule
